// File: rtl/fruit_judge_seq.sv
// Frame sequencer for the fruit classifier: latches features on each vsync,
// samples the sort code after a settle window and majority-votes a window.
module fruit_judge_seq #(
    parameter int SETTLE_CYC  = 4,
    parameter int VOTE_FRAMES = 5
) (
    input  logic       pixelclk,
    input  logic       reset_n,
    input  logic       i_en,
    input  logic       i_vsync,
    input  logic [3:0] i_sort,
    output logic       o_latch_en,
    output logic       o_busy,
    output logic [3:0] o_result,
    output logic [3:0] o_conf,
    output logic       o_valid,
    input  logic       i_ack
);

    typedef enum logic [2:0] {
        IDLE, WAIT_EOF, LATCH, SETTLE, SAMPLE, DECIDE, PRESENT
    } state_t;

    state_t     state_q, state_d;
    logic       vsync_q;
    logic [3:0] hist_q [16];
    logic [3:0] hist_d [16];
    logic [3:0] frm_cnt_q, frm_cnt_d;
    logic [7:0] set_cnt_q, set_cnt_d;
    logic [3:0] scan_idx_q, scan_idx_d;
    logic [3:0] best_idx_q, best_idx_d;
    logic [3:0] best_cnt_q, best_cnt_d;
    logic [3:0] result_q, result_d;
    logic [3:0] conf_q, conf_d;

    logic       vs_edge;
    logic       hit;
    logic [3:0] bin;
    logic [3:0] frm_inc;
    logic       abort;

    assign vs_edge = i_vsync & ~vsync_q;
    assign bin     = hist_q[scan_idx_q];
    assign hit     = bin > best_cnt_q;
    assign frm_inc = frm_cnt_q + 4'd1;
    assign abort   = ~i_en & (state_q inside {WAIT_EOF, LATCH, SETTLE, SAMPLE, DECIDE});

    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        frm_cnt_d  = frm_cnt_q;
        set_cnt_d  = set_cnt_q;
        scan_idx_d = scan_idx_q;
        best_idx_d = best_idx_q;
        best_cnt_d = best_cnt_q;
        result_d   = result_q;
        conf_d     = conf_q;
        unique case (state_q)
            IDLE: begin
                if (i_en) state_d = WAIT_EOF;
            end
            WAIT_EOF: begin
                if (vs_edge) state_d = LATCH;
            end
            LATCH: begin
                set_cnt_d = 8'(SETTLE_CYC);
                state_d   = SETTLE;
            end
            SETTLE: begin
                set_cnt_d = set_cnt_q - 8'd1;
                if (set_cnt_q == 8'd1) state_d = SAMPLE;
            end
            SAMPLE: begin
                hist_d[i_sort] = hist_q[i_sort] + 4'd1;
                frm_cnt_d      = frm_inc;
                if (frm_inc == 4'(VOTE_FRAMES)) begin
                    state_d    = DECIDE;
                    scan_idx_d = 4'd0;
                    best_idx_d = 4'd0;
                    best_cnt_d = 4'd0;
                end else begin
                    state_d = WAIT_EOF;
                end
            end
            DECIDE: begin
                // strict compare keeps the lowest class on ties
                if (hit) begin
                    best_idx_d = scan_idx_q;
                    best_cnt_d = bin;
                end
                scan_idx_d = scan_idx_q + 4'd1;
                if (scan_idx_q == 4'd15) begin
                    result_d = hit ? scan_idx_q : best_idx_q;
                    conf_d   = hit ? bin : best_cnt_q;
                    state_d  = PRESENT;
                end
            end
            PRESENT: begin
                if (i_ack) begin
                    for (int i = 0; i < 16; i++) hist_d[i] = 4'd0;
                    frm_cnt_d = 4'd0;
                    state_d   = i_en ? WAIT_EOF : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            for (int i = 0; i < 16; i++) hist_d[i] = 4'd0;
            frm_cnt_d = 4'd0;
            result_d  = result_q;
            conf_d    = conf_q;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            vsync_q    <= 1'b0;
            for (int i = 0; i < 16; i++) hist_q[i] <= 4'd0;
            frm_cnt_q  <= 4'd0;
            set_cnt_q  <= 8'd0;
            scan_idx_q <= 4'd0;
            best_idx_q <= 4'd0;
            best_cnt_q <= 4'd0;
            result_q   <= 4'd0;
            conf_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            vsync_q    <= i_vsync;
            hist_q     <= hist_d;
            frm_cnt_q  <= frm_cnt_d;
            set_cnt_q  <= set_cnt_d;
            scan_idx_q <= scan_idx_d;
            best_idx_q <= best_idx_d;
            best_cnt_q <= best_cnt_d;
            result_q   <= result_d;
            conf_q     <= conf_d;
        end
    end

    assign o_latch_en = state_q == LATCH;
    assign o_busy     = state_q inside {LATCH, SETTLE, SAMPLE, DECIDE};
    assign o_valid    = state_q == PRESENT;
    assign o_result   = result_q;
    assign o_conf     = conf_q;

endmodule

// File: tb/tb_fruit_judge_seq.sv
// Bench for fruit_judge_seq: frame-timeline model checked every cycle,
// plus directed scenarios with hand-computed votes and latencies.
module tb_fruit_judge_seq;
    localparam int S = 4;
    localparam int V = 5;

    logic       pixelclk = 1'b0;
    logic       reset_n  = 1'b0;
    logic       i_en     = 1'b0;
    logic       i_vsync  = 1'b0;
    logic       i_ack    = 1'b0;
    logic [3:0] i_sort   = 4'd0;
    logic       o_latch_en, o_busy, o_valid;
    logic [3:0] o_result, o_conf;

    int n_cmp = 0;
    int n_bad = 0;
    int n_latch = 0;

    fruit_judge_seq #(.SETTLE_CYC(S), .VOTE_FRAMES(V)) dut (
        .pixelclk  (pixelclk),
        .reset_n   (reset_n),
        .i_en      (i_en),
        .i_vsync   (i_vsync),
        .i_sort    (i_sort),
        .o_latch_en(o_latch_en),
        .o_busy    (o_busy),
        .o_result  (o_result),
        .o_conf    (o_conf),
        .o_valid   (o_valid),
        .i_ack     (i_ack)
    );

    always #5 pixelclk = ~pixelclk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: frame timeline position, decide countdown, sample list
    int         m_t = 0;
    int         m_dleft = 0;
    bit         m_armed = 0;
    bit         m_pres = 0;
    bit         m_mv = 0;
    int         m_q[$];
    logic [3:0] m_res = 4'd0;
    logic [3:0] m_conf = 4'd0;

    function automatic void vote();
        int cnt[16];
        int mx;
        foreach (cnt[i]) cnt[i] = 0;
        foreach (m_q[k]) cnt[m_q[k]]++;
        mx = 0;
        foreach (cnt[i]) if (cnt[i] > mx) mx = cnt[i];
        m_conf = 4'(mx);
        for (int i = 15; i >= 0; i--) if (cnt[i] == mx) m_res = 4'(i);
    endfunction

    initial begin
        forever begin
            @(posedge pixelclk or negedge reset_n);
            if (!reset_n) begin
                m_t = 0; m_dleft = 0; m_armed = 0; m_pres = 0; m_mv = 0;
                m_q.delete(); m_res = 4'd0; m_conf = 4'd0;
            end else begin
                bit e;
                e = i_vsync && !m_mv;
                m_mv = i_vsync;
                if (m_pres) begin
                    if (i_ack) begin
                        m_pres = 0; m_q.delete(); m_armed = i_en;
                    end
                end else if (!i_en && (m_armed || m_t > 0 || m_dleft > 0)) begin
                    m_armed = 0; m_t = 0; m_dleft = 0; m_q.delete();
                end else if (m_dleft > 0) begin
                    m_dleft--;
                    if (m_dleft == 0) begin
                        vote(); m_pres = 1;
                    end
                end else if (m_t == 2 + S) begin
                    m_q.push_back(int'(i_sort));
                    m_t = 0;
                    if (m_q.size() == V) m_dleft = 16;
                    else m_armed = 1;
                end else if (m_t > 0) begin
                    m_t++;
                end else if (m_armed) begin
                    if (e) begin
                        m_t = 1; m_armed = 0;
                    end
                end else if (i_en) begin
                    m_armed = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge pixelclk);
            if (o_latch_en === 1'b1) n_latch++;
            check("latch_en", 32'(o_latch_en), 32'(m_t == 1));
            check("busy", 32'(o_busy), 32'(m_t > 0 || m_dleft > 0));
            check("valid", 32'(o_valid), 32'(m_pres));
            check("result", 32'(o_result), 32'(m_res));
            check("conf", 32'(o_conf), 32'(m_conf));
        end
    end

    task automatic frame(input logic [3:0] s, input bit extra);
        i_sort  = s;
        i_vsync = 1'b1;
        @(negedge pixelclk);
        check("latch_after_edge", 32'(o_latch_en), 32'd1);
        i_vsync = 1'b0;
        @(negedge pixelclk);
        i_vsync = extra;
        @(negedge pixelclk);
        i_vsync = 1'b0;
        repeat (4) @(negedge pixelclk);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (o_valid !== 1'b1 && n < 100) begin
            @(negedge pixelclk);
            n++;
        end
        if (o_valid !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL valid_timeout: got 0 expected 1 within 100 cycles");
        end
    endtask

    task automatic ack();
        i_ack = 1'b1;
        @(negedge pixelclk);
        i_ack = 1'b0;
        check("valid_drop", 32'(o_valid), 32'd0);
    endtask

    initial begin
        int n;
        int base;
        #1;
        check("rst_latch", 32'(o_latch_en), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_result", 32'(o_result), 32'd0);
        check("rst_conf", 32'(o_conf), 32'd0);
        repeat (2) @(negedge pixelclk);
        reset_n = 1'b1;
        i_en = 1'b1;
        i_ack = 1'b1;
        @(negedge pixelclk);

        // five frames of class 7 with ack held high
        repeat (5) frame(4'd7, 1'b0);
        wait_valid(n);
        check("vote_latency", 32'(n), 32'd16);
        check("s1_result", 32'(o_result), 32'd7);
        check("s1_conf", 32'(o_conf), 32'd5);
        @(negedge pixelclk);
        check("s1_valid_one_cycle", 32'(o_valid), 32'd0);
        i_ack = 1'b0;

        // tie between 3 and 5, then a long hold with edges arriving
        frame(4'd5, 1'b0); frame(4'd3, 1'b0); frame(4'd5, 1'b0);
        frame(4'd3, 1'b0); frame(4'd9, 1'b0);
        wait_valid(n);
        check("s2_result", 32'(o_result), 32'd3);
        check("s2_conf", 32'(o_conf), 32'd2);
        repeat (4) begin
            i_vsync = 1'b1;
            @(negedge pixelclk);
            i_vsync = 1'b0;
            repeat (4) @(negedge pixelclk);
        end
        check("s2_hold_valid", 32'(o_valid), 32'd1);
        check("s2_hold_result", 32'(o_result), 32'd3);
        check("s2_hold_conf", 32'(o_conf), 32'd2);
        ack();
        frame(4'd5, 1'b0); frame(4'd5, 1'b0); frame(4'd1, 1'b0);
        frame(4'd1, 1'b0); frame(4'd1, 1'b0);
        wait_valid(n);
        check("s2b_result", 32'(o_result), 32'd1);
        check("s2b_conf", 32'(o_conf), 32'd3);
        ack();

        // extra edges during SETTLE and DECIDE are ignored
        base = n_latch;
        frame(4'd2, 1'b1); frame(4'd2, 1'b1); frame(4'd6, 1'b1);
        frame(4'd6, 1'b1); frame(4'd6, 1'b0);
        i_vsync = 1'b1;
        @(negedge pixelclk);
        i_vsync = 1'b0;
        wait_valid(n);
        check("s3_latch_pulses", 32'(n_latch - base), 32'd5);
        check("s3_result", 32'(o_result), 32'd6);
        check("s3_conf", 32'(o_conf), 32'd3);
        ack();

        // enable dropped after the third sample
        repeat (3) frame(4'd9, 1'b0);
        i_en = 1'b0;
        @(negedge pixelclk);
        check("s4_idle_busy", 32'(o_busy), 32'd0);
        check("s4_idle_result", 32'(o_result), 32'd6);
        i_en = 1'b1;
        @(negedge pixelclk);
        repeat (5) frame(4'd2, 1'b0);
        wait_valid(n);
        check("s4_result", 32'(o_result), 32'd2);
        check("s4_conf", 32'(o_conf), 32'd5);
        ack();

        // asynchronous reset in the middle of DECIDE
        repeat (5) frame(4'd8, 1'b0);
        repeat (5) @(negedge pixelclk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_latch", 32'(o_latch_en), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_result", 32'(o_result), 32'd0);
        check("mid_rst_conf", 32'(o_conf), 32'd0);
        @(negedge pixelclk);
        reset_n = 1'b1;
        repeat (30) @(negedge pixelclk);
        check("post_rst_valid", 32'(o_valid), 32'd0);
        check("post_rst_busy", 32'(o_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
